// File: rtl/hazard_pkg.sv
// Shared encodings and types for the pipeline hazard controller.
package hazard_pkg;

  // Execute-stage operand select encodings.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Multi-cycle sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  // Execute operand select for one source register: Memory beats Writeback,
  // and register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic       rw_m,
    input logic [4:0] wr_m,
    input logic       rw_w,
    input logic [4:0] wr_w,
    input logic [4:0] src
  );
    if (rw_m && (wr_m != 5'd0) && (wr_m == src))      return FWD_MEM;
    else if (rw_w && (wr_w != 5'd0) && (wr_w == src)) return FWD_WB;
    else                                               return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side view of the hazard controller: register ids and stage flags
// in, forwarding selects and stall/flush controls out.
interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       RsD, RtD, RsE, RtE;
  logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE, MemtoRegM;
  logic             BranchD;
  logic             MultiCycleE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             ForwardAD, ForwardBD;
  logic             StallF, StallD, StallE;
  logic             FlushE, FlushM;
  logic             McBusy;
  logic [CNT_W-1:0] StallCycles;

  // Pipeline side: drives stage information, consumes controls.
  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MultiCycleE,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, StallE, FlushE, FlushM, McBusy, StallCycles
  );

  // Hazard controller side.
  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MultiCycleE,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, StallE, FlushE, FlushM, McBusy, StallCycles
  );
endinterface

// File: rtl/mc_sequencer.sv
// Holds a multi-cycle Execute op for MC_LAT cycles; mcstall is high for the
// first MC_LAT-1 of them and drops on the cycle the op leaves Execute.
module mc_sequencer
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic MultiCycleE,
  output logic mcstall
);

  localparam int            CW       = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (MC_LAT > 1) ? CW'(MC_LAT - 2) : '0;

  mc_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  // State and down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state and stall; MultiCycleE is only looked at in IDLE so the held
  // op cannot retrigger itself.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mcstall = 1'b0;
    case (state)
      IDLE: begin
        if (MultiCycleE && (MC_LAT > 1)) begin
          mcstall = 1'b1;
          state_n = BUSY;
          cnt_n   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          mcstall = 1'b1;
          cnt_n   = cnt - 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) mcstall = 1'b0;
  end

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard controller: forwarding selects, load-use and
// branch stalls, multi-cycle Execute holds and a stall-cycle counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_unit_if.slave hz
);

  logic             lwstall, brstall, hzstall, mcstall;
  logic             stall_f;
  logic [CNT_W-1:0] stall_cnt;

  mc_sequencer #(.MC_LAT(MC_LAT)) u_mc (
    .clk         (clk),
    .rst         (rst),
    .MultiCycleE (hz.MultiCycleE),
    .mcstall     (mcstall)
  );

  // Forwarding selects: pure functions of the register ids and write enables.
  always_comb begin
    hz.ForwardAE = fwd_sel(hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW, hz.RsE);
    hz.ForwardBE = fwd_sel(hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW, hz.RtE);
    hz.ForwardAD = hz.RegWriteM && (hz.WriteRegM != 5'd0) && (hz.WriteRegM == hz.RsD);
    hz.ForwardBD = hz.RegWriteM && (hz.WriteRegM != 5'd0) && (hz.WriteRegM == hz.RtD);
  end

  // Load-use and branch-compare hazards detected in Decode.
  always_comb begin
    lwstall = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));
    brstall = hz.BranchD &&
              ((hz.RegWriteE && (hz.WriteRegE != 5'd0) &&
                ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
               (hz.MemtoRegM && (hz.WriteRegM != 5'd0) &&
                ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));
    hzstall = (lwstall || brstall) && !rst;
  end

  // Stall/flush controls; a multi-cycle hold overrides Decode hazards and
  // bubbles Memory instead of Execute.
  always_comb begin
    stall_f   = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushM = 1'b0;
    if (mcstall) begin
      stall_f   = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.FlushM = 1'b1;
    end else if (hzstall) begin
      stall_f   = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
    hz.StallF = stall_f;
    hz.McBusy = mcstall;
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_f && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign hz.StallCycles = stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: combinational vector table, random vectors against a
// reference model, and hand-written multi-cycle, reset and saturation runs.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int MC_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int W      = 12;
  localparam int NV     = 18;

  logic clk = 1'b0;
  logic rst;

  // Clock generation.
  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(CNT_W)) hif ();

  hazard_unit #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, rw_m, rw_w, mem_e, mem_m, br_d;
    logic [W-1:0] exp;
    string      name;
  } vec_t;

  vec_t         vecs[NV];
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad   = 0;

  // Packed output order: {ForwardAE, ForwardBE, ForwardAD, ForwardBD,
  // StallF, StallD, StallE, FlushE, FlushM, McBusy}.
  function automatic logic [W-1:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic fad, input logic fbd,
                                      input logic sf, input logic sd, input logic se,
                                      input logic fe, input logic fm, input logic busy);
    return {fa, fb, fad, fbd, sf, sd, se, fe, fm, busy};
  endfunction

  function automatic vec_t mkv(input logic [4:0] rs_d, input logic [4:0] rt_d,
                               input logic [4:0] rs_e, input logic [4:0] rt_e,
                               input logic [4:0] wr_e, input logic [4:0] wr_m,
                               input logic [4:0] wr_w, input logic rw_e,
                               input logic rw_m, input logic rw_w, input logic mem_e,
                               input logic mem_m, input logic br_d,
                               input logic [W-1:0] exp, input string name);
    vec_t v;
    v.rs_d = rs_d; v.rt_d = rt_d; v.rs_e = rs_e; v.rt_e = rt_e;
    v.wr_e = wr_e; v.wr_m = wr_m; v.wr_w = wr_w;
    v.rw_e = rw_e; v.rw_m = rw_m; v.rw_w = rw_w;
    v.mem_e = mem_e; v.mem_m = mem_m; v.br_d = br_d;
    v.exp = exp; v.name = name;
    return v;
  endfunction

  // Reference model of the combinational behaviour with the sequencer idle.
  function automatic logic [W-1:0] model(input vec_t v);
    logic [1:0] fa, fb;
    logic       fad, fbd, lw, br, st;
    if (v.rw_m && v.wr_m != 0 && v.wr_m == v.rs_e)      fa = 2'b10;
    else if (v.rw_w && v.wr_w != 0 && v.wr_w == v.rs_e) fa = 2'b01;
    else                                                fa = 2'b00;
    if (v.rw_m && v.wr_m != 0 && v.wr_m == v.rt_e)      fb = 2'b10;
    else if (v.rw_w && v.wr_w != 0 && v.wr_w == v.rt_e) fb = 2'b01;
    else                                                fb = 2'b00;
    fad = v.rw_m && v.wr_m != 0 && v.wr_m == v.rs_d;
    fbd = v.rw_m && v.wr_m != 0 && v.wr_m == v.rt_d;
    lw  = v.mem_e && (v.rt_e == v.rs_d || v.rt_e == v.rt_d);
    br  = v.br_d && ((v.rw_e && v.wr_e != 0 && (v.wr_e == v.rs_d || v.wr_e == v.rt_d)) ||
                     (v.mem_m && v.wr_m != 0 && (v.wr_m == v.rs_d || v.wr_m == v.rt_d)));
    st  = lw || br;
    return mk(fa, fb, fad, fbd, st, st, 1'b0, st, 1'b0, 1'b0);
  endfunction

  function automatic logic [W-1:0] outs();
    return {hif.ForwardAE, hif.ForwardBE, hif.ForwardAD, hif.ForwardBD,
            hif.StallF, hif.StallD, hif.StallE, hif.FlushE, hif.FlushM, hif.McBusy};
  endfunction

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hif.RsD = '0; hif.RtD = '0; hif.RsE = '0; hif.RtE = '0;
    hif.WriteRegE = '0; hif.WriteRegM = '0; hif.WriteRegW = '0;
    hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
    hif.BranchD = 1'b0; hif.MultiCycleE = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    hif.RsD = v.rs_d; hif.RtD = v.rt_d; hif.RsE = v.rs_e; hif.RtE = v.rt_e;
    hif.WriteRegE = v.wr_e; hif.WriteRegM = v.wr_m; hif.WriteRegW = v.wr_w;
    hif.RegWriteE = v.rw_e; hif.RegWriteM = v.rw_m; hif.RegWriteW = v.rw_w;
    hif.MemtoRegE = v.mem_e; hif.MemtoRegM = v.mem_m;
    hif.BranchD = v.br_d; hif.MultiCycleE = 1'b0;
  endtask

  // Leaves the bench one ns after a reset edge with rst low: the cycle now
  // running is the first free cycle.
  task automatic do_reset();
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard.
  task automatic expect_outs(input logic [W-1:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic compare_outs();
    logic [W-1:0] e, got;
    string        n;
    #1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      got = outs();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got=%b want=%b", n, got, e);
      end
    end
  endtask

  task automatic check_cnt(input logic [CNT_W-1:0] e, input string n);
    total++;
    if (hif.StallCycles !== e) begin
      bad++;
      $display("FAIL %s: StallCycles got=%0d want=%0d", n, hif.StallCycles, e);
    end
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Main test sequence.
  initial begin
    logic [W-1:0] zero, mcx, lwx;
    vec_t         rv;
    zero = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    mcx  = mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 1, 1);
    lwx  = mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 0, 0);

    //            rs_d rt_d rs_e rt_e wr_e wr_m wr_w rwE rwM rwW memE memM br
    vecs[0]  = mkv(1, 2, 5, 9, 20, 5, 5, 0, 1, 1, 0, 0, 0, mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "fwd_a_mem_prio");
    vecs[1]  = mkv(1, 2, 5, 9, 20, 5, 5, 0, 0, 1, 0, 0, 0, mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "fwd_a_wb");
    vecs[2]  = mkv(1, 2, 0, 0, 20, 0, 0, 0, 1, 1, 0, 0, 0, zero, "fwd_a_r0");
    vecs[3]  = mkv(1, 2, 11, 6, 20, 6, 11, 0, 1, 1, 0, 0, 0, mk(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0), "fwd_b_mem");
    vecs[4]  = mkv(1, 2, 3, 12, 20, 12, 12, 0, 0, 1, 0, 0, 0, mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0), "fwd_b_wb");
    vecs[5]  = mkv(8, 9, 1, 2, 20, 8, 0, 0, 1, 0, 0, 0, 0, mk(2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0), "fwd_ad");
    vecs[6]  = mkv(9, 8, 1, 2, 20, 8, 0, 0, 1, 0, 0, 0, 0, mk(2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0), "fwd_bd");
    vecs[7]  = mkv(0, 0, 1, 2, 20, 0, 0, 0, 1, 0, 0, 0, 0, zero, "fwd_d_r0");
    vecs[8]  = mkv(7, 3, 4, 7, 7, 0, 0, 1, 0, 0, 1, 0, 0, lwx, "loaduse_rs");
    vecs[9]  = mkv(3, 7, 4, 7, 7, 0, 0, 1, 0, 0, 1, 0, 0, lwx, "loaduse_rt");
    vecs[10] = mkv(3, 4, 4, 7, 7, 0, 0, 1, 0, 0, 1, 0, 0, zero, "loaduse_none");
    vecs[11] = mkv(3, 4, 1, 2, 3, 0, 0, 1, 0, 0, 0, 0, 1, lwx, "br_exe");
    vecs[12] = mkv(3, 4, 1, 2, 10, 3, 0, 1, 1, 0, 0, 0, 1, mk(2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0), "br_mem_alu");
    vecs[13] = mkv(4, 3, 1, 2, 10, 3, 0, 1, 1, 0, 0, 1, 1, mk(2'b00, 2'b00, 0, 1, 1, 1, 0, 1, 0, 0), "br_mem_load");
    vecs[14] = mkv(0, 4, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 1, zero, "br_exe_r0");
    vecs[15] = mkv(3, 4, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1, zero, "br_exe_nowrite");
    vecs[16] = mkv(3, 4, 1, 2, 3, 0, 0, 1, 0, 0, 0, 0, 0, zero, "no_branch");
    vecs[17] = mkv(0, 4, 1, 2, 10, 0, 0, 0, 1, 0, 0, 1, 1, zero, "br_mem_r0");

    // Reset behaviour: stalls suppressed, forwarding still live.
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    hif.MemtoRegE = 1'b1; hif.RtE = 5'd7; hif.RsD = 5'd7;
    hif.MultiCycleE = 1'b1;
    hif.RsE = 5'd5; hif.WriteRegM = 5'd5; hif.RegWriteM = 1'b1;
    expect_outs(mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "in_reset");
    compare_outs();
    tick();
    idle_inputs();
    rst = 1'b0;
    expect_outs(zero, "after_reset");
    compare_outs();
    check_cnt(0, "after_reset_cnt");

    // Combinational vector table.
    for (int i = 0; i < NV; i++) begin
      tick();
      drive_vec(vecs[i]);
      expect_outs(vecs[i].exp, vecs[i].name);
      compare_outs();
    end

    // Random vectors on a small register set to force collisions.
    for (int i = 0; i < 40; i++) begin
      tick();
      rv.rs_d = 5'($urandom_range(0, 3)); rv.rt_d = 5'($urandom_range(0, 3));
      rv.rs_e = 5'($urandom_range(0, 3)); rv.rt_e = 5'($urandom_range(0, 3));
      rv.wr_e = 5'($urandom_range(0, 3)); rv.wr_m = 5'($urandom_range(0, 3));
      rv.wr_w = 5'($urandom_range(0, 3));
      rv.rw_e = 1'($urandom_range(0, 1)); rv.rw_m = 1'($urandom_range(0, 1));
      rv.rw_w = 1'($urandom_range(0, 1)); rv.mem_e = 1'($urandom_range(0, 1));
      rv.mem_m = 1'($urandom_range(0, 1)); rv.br_d = 1'($urandom_range(0, 1));
      rv.name = "random";
      drive_vec(rv);
      expect_outs(model(rv), "random");
      compare_outs();
    end

    // Multi-cycle op held high, then a back-to-back second op.
    do_reset();
    hif.MultiCycleE = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      if (c == 6) hif.MultiCycleE = 1'b0;
      expect_outs((c == 4 || c == 8) ? zero : mcx, $sformatf("mc_cycle%0d", c));
      compare_outs();
      if (c == 5) check_cnt(3, "mc_first_cnt");
      if (c == 8) check_cnt(6, "mc_b2b_cnt");
    end

    // Load-use arising during a hold is seen after release.
    do_reset();
    hif.MultiCycleE = 1'b1;
    hif.MemtoRegE = 1'b1; hif.RtE = 5'd7; hif.RsD = 5'd7;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) tick();
      if (c == 2) hif.MultiCycleE = 1'b0;
      if (c == 5) idle_inputs();
      expect_outs((c <= 3) ? mcx : (c == 4) ? lwx : zero, $sformatf("mc_lw_cycle%0d", c));
      compare_outs();
      if (c == 5) check_cnt(4, "mc_lw_cnt");
    end

    // Reset in the second cycle of a hold abandons the op.
    do_reset();
    hif.MultiCycleE = 1'b1;
    expect_outs(mcx, "rst_mid_c1");
    compare_outs();
    tick();
    rst = 1'b1;
    expect_outs(zero, "rst_mid_c2");
    compare_outs();
    tick();
    rst = 1'b0;
    hif.MultiCycleE = 1'b0;
    expect_outs(zero, "rst_mid_c3");
    compare_outs();
    check_cnt(0, "rst_mid_cnt");
    tick();
    expect_outs(zero, "rst_mid_c4");
    compare_outs();

    // Counter saturation with a persistent load-use stall.
    do_reset();
    hif.MemtoRegE = 1'b1; hif.RtE = 5'd7; hif.RsD = 5'd7;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) tick();
      expect_outs(lwx, "sat_outs");
      compare_outs();
      check_cnt((i > 15) ? CNT_W'(15) : CNT_W'(i), $sformatf("sat_cnt%0d", i));
    end
    tick();
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage core. It drives the Execute-stage operand forwarding selects, the Decode-stage branch-compare forwarding, and the fetch/decode/execute stall and flush controls. It also sequences multi-cycle Execute operations by holding Execute for a programmed latency, and keeps a stall-cycle performance counter. It sits beside the pipeline registers and is purely a control block; it carries no datapath words.

## Interface
- `MC_LAT`, default 4: total cycles a multi-cycle op occupies Execute; legal range 1..16; 1 disables sequencing.
- `CNT_W`, default 32: width of the stall-cycle counter.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `RsD`, `RtD`  in  5 each  source registers in Decode.
- `RsE`, `RtE`  in  5 each  source registers in Execute.
- `WriteRegE`, `WriteRegM`, `WriteRegW`  in  5 each  destination register per stage.
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1 each  register-write enable per stage.
- `MemtoRegE`, `MemtoRegM`  in  1 each  instruction in that stage is a load.
- `BranchD`  in  1  branch in Decode; it compares its operands in Decode.
- `MultiCycleE`  in  1  instruction in Execute is a multi-cycle op.
- `ForwardAE`, `ForwardBE`  out  2 each  Execute operand select: 00 register file, 01 ResultW, 10 ALUOutM.
- `ForwardAD`, `ForwardBD`  out  1 each  Decode compare operand takes ALUOutM.
- `StallF`, `StallD`, `StallE`  out  1 each  hold the PC, the IF/ID register and the ID/EX register.
- `FlushE`, `FlushM`  out  1 each  insert a bubble into ID/EX or EX/MEM.
- `McBusy`  out  1  multi-cycle sequencer is active.
- `StallCycles`  out  CNT_W  saturating count of cycles with `StallF`=1.

## Operation
- **Execute forwarding (A; B identical using RtE):**
  - 10 if `RegWriteM` && `WriteRegM`!=0 && `WriteRegM`==`RsE`.
  - Otherwise 01 if `RegWriteW` && `WriteRegW`!=0 && `WriteRegW`==`RsE`.
  - Otherwise 00.
  - The Memory stage wins over Writeback when both match.
- **Decode forwarding:** `ForwardAD` = `RegWriteM` && `WriteRegM`!=0 && `WriteRegM`==`RsD`. `ForwardBD` is the same against `RtD`.
- **Load-use hazard (lwstall):** `MemtoRegE` && (`RtE`==`RsD` || `RtE`==`RtD`).
- **Branch hazard (brstall):** `BranchD` and either:
  - `RegWriteE` && `WriteRegE`!=0 && `WriteRegE` matches `RsD` or `RtD`, or
  - `MemtoRegM` && `WriteRegM`!=0 && `WriteRegM` matches `RsD` or `RtD`.
- **Multi-cycle sequencer FSM**, states IDLE and BUSY, with down-counter `cnt` of width clog2(MC_LAT).
  - IDLE, `MultiCycleE`=1, MC_LAT>1: mcstall=1; go to BUSY; `cnt` <= MC_LAT-2.
  - BUSY, `cnt`!=0: mcstall=1; `cnt` decrements.
  - BUSY, `cnt`==0: mcstall=0; go to IDLE. The op leaves Execute on this edge.
  - `MultiCycleE` is sampled only in IDLE, so the held op never retriggers.
  - `McBusy` = mcstall.
- **Output equations:**
  - mcstall=1: `StallF`=`StallD`=`StallE`=1, `FlushM`=1, `FlushE`=0. This overrides lwstall and brstall; Execute must hold.
  - Otherwise: `StallF`=`StallD`=`FlushE`=lwstall||brstall, and `StallE`=`FlushM`=0.
- **StallCycles:** increments by 1 on each edge where `StallF`=1. It holds at all-ones; no wrap.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the current state; there is zero-cycle latency.
- A multi-cycle op holds Execute for exactly MC_LAT cycles and causes MC_LAT-1 stall cycles.
- With MC_LAT=1, `MultiCycleE` is ignored.
- **While `rst`=1:**
  - All stall and flush outputs and `McBusy` are 0.
  - The forwarding outputs follow their combinational equations.
- **On the edge with `rst`=1:**
  - The FSM goes to IDLE.
  - `cnt` and `StallCycles` clear to 0.
  - A reset in mid-BUSY abandons the op; outputs are clean in the next cycle.
- A load-use condition arising while BUSY is re-evaluated after release. Decode is still held, so no hazard is lost.
- Back-to-back multi-cycle ops: the second is sampled in the IDLE cycle right after release, giving no gap cycle.

## Structure
- Package `hazard_pkg` holds:
  - the forward encodings `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10;
  - the FSM state type (IDLE, BUSY).
- Sub-module `mc_sequencer` holds the FSM and `cnt`. Its ports are `clk`, `rst`, `MultiCycleE` and `mcstall`.
- The forwarding, hazard logic and perf counter live in `hazard_unit` itself.

## Test plan
- **Forwarding priority:** `RsE`=5; `WriteRegM`=5 and `WriteRegW`=5 with both write enables set → `ForwardAE`=10. Drop `RegWriteM` → 01. Set `RsE`=0 with all matching → 00.
- **Load-use:** `MemtoRegE`=1, `RtE`=7, `RsD`=7 → `StallF`=`StallD`=`FlushE`=1 for one cycle; `StallCycles` goes 0→1.
- **Branch hazard:** `BranchD`=1, `RsD`=3, `RegWriteE`=1, `WriteRegE`=3 → stall with flush. With the hazard instead in M, a non-load ALU op gives `ForwardAD`=1 and no stall.
- **Multi-cycle, MC_LAT=4:** pulse `MultiCycleE` held high → `StallE`=`FlushM`=`McBusy`=1 for cycles 1-3 and 0 in cycle 4; `StallCycles`=3.
- **Reset mid-BUSY:** assert `rst` in cycle 2 of a 4-cycle op → next cycle FSM is IDLE, all stalls 0, `StallCycles`=0.
- **Saturation:** with CNT_W=4, force 20 stall cycles → `StallCycles` holds at 15.
